// File: rtl/clkgen_pkg.sv
// Shared constants and helpers for the clock-enable / reset generator.
package clkgen_pkg;

    localparam int unsigned DIV_W_DEFAULT = 8;
    localparam int unsigned MAX_CH        = 8;

    // A programmed divisor of zero behaves as divide-by-one.
    function automatic int unsigned sanitise(input int unsigned n);
        return (n == 32'd0) ? 32'd1 : n;
    endfunction

    // Number of high cycles of the divided square wave for ratio n.
    function automatic int unsigned ceil_half(input int unsigned n);
        return (n + 32'd1) / 32'd2;
    endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One runtime-programmable clock-enable divider channel.
// Optional square-wave output under CLK_DIV_OUT_EN.
// clear is the registered downstream reset; clear_next is its next value so
// the registered outputs can come out of reset already in phase.
module clock_divider_channel
    import clkgen_pkg::*;
#(
    parameter int unsigned      DIV_W       = DIV_W_DEFAULT,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             clear_next,
    input  logic [DIV_W-1:0] value,
    input  logic             load,
    output logic             busy,
    output logic             ce
`ifdef CLK_DIV_OUT_EN
    ,
    output logic             clk_div
`endif
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] active;
    logic [DIV_W-1:0] pending;

    logic [DIV_W-1:0] cnt_n;
    logic [DIV_W-1:0] active_n;
    logic [DIV_W-1:0] pending_n;
    logic             busy_n;
    logic [DIV_W-1:0] next_eff;
    logic             ce_n;

    // Next-state: load handling, terminal-count swap and counter advance.
    always_comb begin
        cnt_n     = cnt;
        active_n  = active;
        pending_n = pending;
        busy_n    = busy;

        if (clear) begin
            // Held in reset: loads go straight to the active divisor.
            cnt_n = '0;
            if (load) begin
                active_n = value;
                busy_n   = 1'b0;
            end
        end else begin
            if (ce) begin
                cnt_n = '0;
                if (busy) begin
                    active_n = pending;
                    busy_n   = 1'b0;
                end
            end else begin
                cnt_n = cnt + DIV_W'(1);
            end
            // Capture after the swap so a coincident load waits a full period.
            if (load) begin
                pending_n = value;
                busy_n    = 1'b1;
            end
        end

        if (clear_next) begin
            cnt_n = '0;
        end

        next_eff = DIV_W'(sanitise(32'(active_n)));
        ce_n     = !clear_next && (cnt_n == (next_eff - DIV_W'(1)));
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            active  <= DEFAULT_DIV;
            pending <= DEFAULT_DIV;
            busy    <= 1'b0;
            ce      <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            active  <= active_n;
            pending <= pending_n;
            busy    <= busy_n;
            ce      <= ce_n;
        end
    end

`ifdef CLK_DIV_OUT_EN
    logic clk_div_n;

    // Square wave high for the first ceil(N/2) counts of each period.
    always_comb begin
        clk_div_n = !clear_next && (32'(cnt_n) < ceil_half(32'(next_eff)));
    end

    // Registered square-wave output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_div <= 1'b0;
        end else begin
            clk_div <= clk_div_n;
        end
    end
`endif

endmodule

// File: rtl/clock_divider_bank.sv
// Clock-enable and stretched-reset generator for the PLL output clock domain.
// Define CLK_DIV_OUT_EN to add the per-channel clk_div square-wave output.
module clock_divider_bank
    import clkgen_pkg::*;
#(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned DIV_W        = DIV_W_DEFAULT,
    parameter int unsigned RESET_CYCLES = 32,
    parameter logic [NUM_CH*DIV_W-1:0] DEFAULT_DIV = {NUM_CH{DIV_W'(2)}}
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    locked,
    input  logic [NUM_CH*DIV_W-1:0] div_value,
    input  logic [NUM_CH-1:0]       div_load,
    output logic [NUM_CH-1:0]       div_busy,
    output logic                    reset_out,
    output logic [NUM_CH-1:0]       ce
`ifdef CLK_DIV_OUT_EN
    ,
    output logic [NUM_CH-1:0]       clk_div
`endif
);

    localparam int unsigned CNT_W = $clog2(RESET_CYCLES + 1);

    if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
        $error("clock_divider_bank: NUM_CH out of range");
    end
    if (RESET_CYCLES < 2) begin : g_bad_reset_cycles
        $error("clock_divider_bank: RESET_CYCLES must be at least 2");
    end

    logic             lock_meta;
    logic             lock_s;
    logic [CNT_W-1:0] rst_cnt;
    logic [CNT_W-1:0] rst_cnt_n;
    logic             reset_next;

    // Two-flop synchroniser for the asynchronous lock indication.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= locked;
            lock_s    <= lock_meta;
        end
    end

    // Lock-stable counter: clears on lock loss, saturates at RESET_CYCLES.
    always_comb begin
        rst_cnt_n = rst_cnt;
        if (!lock_s) begin
            rst_cnt_n = '0;
        end else if (rst_cnt != CNT_W'(RESET_CYCLES)) begin
            rst_cnt_n = rst_cnt + CNT_W'(1);
        end
        reset_next = (rst_cnt_n != CNT_W'(RESET_CYCLES));
    end

    // Counter and registered downstream reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_cnt   <= '0;
            reset_out <= 1'b1;
        end else begin
            rst_cnt   <= rst_cnt_n;
            reset_out <= reset_next;
        end
    end

    // Independent divider channels, each fed its own divisor slice.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clock_divider_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV[g*DIV_W +: DIV_W])
        ) u_channel (
            .clk        (clk),
            .reset      (reset),
            .clear      (reset_out),
            .clear_next (reset_next),
            .value      (div_value[g*DIV_W +: DIV_W]),
            .load       (div_load[g]),
            .busy       (div_busy[g]),
            .ce         (ce[g])
`ifdef CLK_DIV_OUT_EN
            ,
            .clk_div    (clk_div[g])
`endif
        );
    end

endmodule
